// File: rtl/wb_commit_if.sv
// Write-back to commit bundle: instruction result in, architectural
// state and status out.
interface wb_commit_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 16
);
    logic [3:0]            start;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  reg_update;
    logic [DATA_W-1:0]     reg_new;
    logic                  pc_update;
    logic [DATA_W-1:0]     pc_new;
    logic                  stall;
    logic [REG_ADDR_W-1:0] rs_addr;
    logic [REG_ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [DATA_W-1:0]     pc;
    logic                  commit_pulse;
    logic [CNT_W-1:0]      commit_cnt;
    logic                  pending;
    logic                  err_both;
    logic                  err_ovf;

    modport master (
        output start, rd_addr, reg_update, reg_new,
        output pc_update, pc_new, stall, rs_addr, rt_addr,
        input  rs_data, rt_data, pc, commit_pulse,
        input  commit_cnt, pending, err_both, err_ovf
    );

    modport slave (
        input  start, rd_addr, reg_update, reg_new,
        input  pc_update, pc_new, stall, rs_addr, rt_addr,
        output rs_data, rt_data, pc, commit_pulse,
        output commit_cnt, pending, err_both, err_ovf
    );
endinterface

// File: rtl/wb_commit.sv
// Commits write-back results to the register file and PC, once per
// write phase, with a one-entry holding buffer for stalls.
module wb_commit #(
    parameter int                DATA_W     = 32,
    parameter int                REG_ADDR_W = 3,
    parameter logic [DATA_W-1:0] PC_RESET   = '0,
    parameter int                PC_STEP    = 4,
    parameter int                CNT_W      = 16
) (
    input logic         clk,
    input logic         rst_n,
    wb_commit_if.slave  bus
);
    localparam int NREG = 2 ** REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_we;
        logic [DATA_W-1:0]     reg_data;
        logic                  pc_ld;
        logic [DATA_W-1:0]     pc_data;
    } entry_t;

    entry_t            buf_q, buf_d, new_e, app_e;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pending_q, pending_d;
    logic              err_both_q, err_both_d;
    logic              err_ovf_q, err_ovf_d;
    logic              pulse_q, start3_q;
    logic              ev, apply, wr_en;
    logic [2:0]        unused_start;

    assign unused_start = bus.start[2:0];
    assign ev = bus.start[3] & ~start3_q;

    // A PC load takes priority; the paired register write is dropped.
    always_comb begin
        new_e.rd       = bus.rd_addr;
        new_e.reg_we   = bus.reg_update & ~bus.pc_update;
        new_e.reg_data = bus.reg_new;
        new_e.pc_ld    = bus.pc_update;
        new_e.pc_data  = bus.pc_new;
    end

    always_comb begin
        buf_d      = buf_q;
        pending_d  = pending_q;
        apply      = 1'b0;
        app_e      = buf_q;
        err_ovf_d  = err_ovf_q;
        err_both_d = err_both_q | (ev & bus.reg_update & bus.pc_update);
        if (pending_q) begin
            if (!bus.stall) begin
                apply = 1'b1;
                if (ev) buf_d = new_e;
                else    pending_d = 1'b0;
            end else if (ev) begin
                err_ovf_d = 1'b1;
            end
        end else if (ev) begin
            if (!bus.stall) begin
                apply = 1'b1;
                app_e = new_e;
            end else begin
                buf_d     = new_e;
                pending_d = 1'b1;
            end
        end
        pc_d  = pc_q;
        cnt_d = cnt_q;
        if (apply) begin
            pc_d  = app_e.pc_ld ? app_e.pc_data
                                : pc_q + DATA_W'(PC_STEP);
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign wr_en = apply & app_e.reg_we & (app_e.rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q      <= '0;
            pc_q       <= PC_RESET;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            err_both_q <= 1'b0;
            err_ovf_q  <= 1'b0;
            pulse_q    <= 1'b0;
            start3_q   <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            buf_q      <= buf_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            err_both_q <= err_both_d;
            err_ovf_q  <= err_ovf_d;
            pulse_q    <= apply;
            start3_q   <= bus.start[3];
            if (wr_en) regs_q[app_e.rd] <= app_e.reg_data;
        end
    end

    // Reads see a write being applied this cycle.
    always_comb begin
        bus.rs_data = regs_q[bus.rs_addr];
        if (wr_en && bus.rs_addr == app_e.rd) bus.rs_data = app_e.reg_data;
        if (bus.rs_addr == '0) bus.rs_data = '0;
        bus.rt_data = regs_q[bus.rt_addr];
        if (wr_en && bus.rt_addr == app_e.rd) bus.rt_data = app_e.reg_data;
        if (bus.rt_addr == '0) bus.rt_data = '0;
    end

    assign bus.pc           = pc_q;
    assign bus.commit_pulse = pulse_q;
    assign bus.commit_cnt   = cnt_q;
    assign bus.pending      = pending_q;
    assign bus.err_both     = err_both_q;
    assign bus.err_ovf      = err_ovf_q;
endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: scoreboard of expected pc and
// commit count, one task per scenario.
module tb_wb_commit;
    localparam int DW = 32;
    localparam int AW = 3;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_commit_if #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) bus ();

    wb_commit #(
        .DATA_W(DW), .REG_ADDR_W(AW), .PC_RESET('0),
        .PC_STEP(4), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int passes = 0;
    logic [DW-1:0] m_pc;
    logic [CW-1:0] m_cnt;
    logic [DW-1:0] exp_pc_q [$];
    logic [CW-1:0] exp_cnt_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.start      = '0;
        bus.rd_addr    = '0;
        bus.reg_update = 1'b0;
        bus.reg_new    = '0;
        bus.pc_update  = 1'b0;
        bus.pc_new     = '0;
        bus.stall      = 1'b0;
        bus.rs_addr    = '0;
        bus.rt_addr    = '0;
    endtask

    task automatic drive_ev(input logic [AW-1:0] rd, input logic ru,
                            input logic [DW-1:0] rn, input logic pu,
                            input logic [DW-1:0] pn);
        bus.start      = 4'b1000;
        bus.rd_addr    = rd;
        bus.reg_update = ru;
        bus.reg_new    = rn;
        bus.pc_update  = pu;
        bus.pc_new     = pn;
        m_pc  = pu ? pn : m_pc + 32'd4;
        m_cnt = m_cnt + 1'b1;
        exp_pc_q.push_back(m_pc);
        exp_cnt_q.push_back(m_cnt);
    endtask

    task automatic wait_commit(input string name);
        int n = 0;
        logic [DW-1:0] ep;
        logic [CW-1:0] ec;
        while (bus.commit_pulse !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (bus.commit_pulse !== 1'b1 || exp_pc_q.size() == 0) begin
            $display("FAIL %s: no commit_pulse (got %b, want 1) or empty scoreboard",
                     name, bus.commit_pulse);
            if (exp_pc_q.size() != 0) begin
                void'(exp_pc_q.pop_front());
                void'(exp_cnt_q.pop_front());
            end
        end else begin
            passes++;
            ep = exp_pc_q.pop_front();
            ec = exp_cnt_q.pop_front();
            checks++;
            if (bus.pc !== ep)
                $display("FAIL %s pc: got %h want %h", name, bus.pc, ep);
            else passes++;
            checks++;
            if (bus.commit_cnt !== ec)
                $display("FAIL %s cnt: got %h want %h", name, bus.commit_cnt, ec);
            else passes++;
        end
    endtask

    task automatic commit_one(input string name, input logic [AW-1:0] rd,
                              input logic ru, input logic [DW-1:0] rn,
                              input logic pu, input logic [DW-1:0] pn);
        drive_ev(rd, ru, rn, pu, pn);
        tick();
        bus.start = '0;
        wait_commit(name);
        tick();
    endtask

    task automatic test_reset();
        checks++;
        if (bus.pc !== 32'h0) $display("FAIL rst_pc: got %h want 0", bus.pc);
        else passes++;
        checks++;
        if (bus.commit_cnt !== '0) $display("FAIL rst_cnt: got %h want 0", bus.commit_cnt);
        else passes++;
        checks++;
        if (bus.pending !== 1'b0) $display("FAIL rst_pending: got %b want 0", bus.pending);
        else passes++;
        checks++;
        if (bus.commit_pulse !== 1'b0) $display("FAIL rst_pulse: got %b want 0", bus.commit_pulse);
        else passes++;
        checks++;
        if ({bus.err_both, bus.err_ovf} !== 2'b00)
            $display("FAIL rst_err: got %b%b want 00", bus.err_both, bus.err_ovf);
        else passes++;
        for (int a = 0; a < 8; a++) begin
            bus.rs_addr = AW'(a);
            #1;
            checks++;
            if (bus.rs_data !== 32'h0)
                $display("FAIL rst_reg%0d: got %h want 0", a, bus.rs_data);
            else passes++;
        end
    endtask

    task automatic test_alu_write();
        drive_ev(3'd3, 1'b1, 32'hDEADBEEF, 1'b0, '0);
        tick();
        wait_commit("alu");
        tick();
        checks++;
        if (bus.commit_pulse !== 1'b0)
            $display("FAIL alu_single_pulse: got %b want 0", bus.commit_pulse);
        else passes++;
        bus.start = '0;
        bus.rs_addr = 3'd3;
        tick();
        checks++;
        if (bus.rs_data !== 32'hDEADBEEF)
            $display("FAIL alu_r3: got %h want deadbeef", bus.rs_data);
        else passes++;
    endtask

    task automatic test_branch();
        commit_one("seq_to_8", 3'd0, 1'b0, '0, 1'b0, '0);
        commit_one("branch", 3'd0, 1'b0, '0, 1'b1, 32'h40);
        checks++;
        if (bus.err_both !== 1'b0) $display("FAIL err_both_early: got %b want 0", bus.err_both);
        else passes++;
        commit_one("both", 3'd3, 1'b1, 32'h1234, 1'b1, 32'h40);
        bus.rs_addr = 3'd3;
        #1;
        checks++;
        if (bus.rs_data !== 32'hDEADBEEF)
            $display("FAIL both_r3: got %h want deadbeef", bus.rs_data);
        else passes++;
        checks++;
        if (bus.err_both !== 1'b1) $display("FAIL err_both: got %b want 1", bus.err_both);
        else passes++;
    endtask

    task automatic test_stall();
        bus.stall = 1'b1;
        bus.rs_addr = 3'd2;
        drive_ev(3'd2, 1'b1, 32'd5, 1'b0, '0);
        tick();
        bus.start = '0;
        checks++;
        if (bus.pending !== 1'b1) $display("FAIL stall_pending: got %b want 1", bus.pending);
        else passes++;
        tick();
        tick();
        checks++;
        if (bus.commit_pulse !== 1'b0 || bus.rs_data !== 32'h0)
            $display("FAIL stall_hold: got pulse %b r2 %h want 0 0", bus.commit_pulse, bus.rs_data);
        else passes++;
        bus.stall = 1'b0;
        #1;
        checks++;
        if (bus.rs_data !== 32'd5) $display("FAIL stall_bypass: got %h want 5", bus.rs_data);
        else passes++;
        tick();
        wait_commit("stall");
        checks++;
        if (bus.pending !== 1'b0 || bus.rs_data !== 32'd5)
            $display("FAIL stall_done: got pending %b r2 %h want 0 5", bus.pending, bus.rs_data);
        else passes++;
        tick();
    endtask

    task automatic test_back_to_back();
        bus.stall = 1'b1;
        drive_ev(3'd6, 1'b1, 32'h66, 1'b0, '0);
        tick();
        bus.start = '0;
        tick();
        bus.stall = 1'b0;
        bus.rt_addr = 3'd6;
        drive_ev(3'd7, 1'b1, 32'h77, 1'b0, '0);
        #1;
        checks++;
        if (bus.rt_data !== 32'h66) $display("FAIL b2b_bypass: got %h want 66", bus.rt_data);
        else passes++;
        tick();
        bus.start = '0;
        wait_commit("b2b_a");
        checks++;
        if (bus.pending !== 1'b1) $display("FAIL b2b_pending: got %b want 1", bus.pending);
        else passes++;
        tick();
        wait_commit("b2b_b");
        bus.rs_addr = 3'd7;
        #1;
        checks++;
        if (bus.pending !== 1'b0 || bus.rs_data !== 32'h77)
            $display("FAIL b2b_done: got pending %b r7 %h want 0 77", bus.pending, bus.rs_data);
        else passes++;
        tick();
    endtask

    task automatic test_overflow_r0();
        bus.stall = 1'b1;
        drive_ev(3'd4, 1'b1, 32'd9, 1'b0, '0);
        tick();
        bus.start = '0;
        tick();
        bus.start = 4'b1000;
        bus.rd_addr = 3'd5;
        bus.reg_new = 32'd11;
        tick();
        bus.start = '0;
        checks++;
        if (bus.err_ovf !== 1'b1 || bus.pending !== 1'b1)
            $display("FAIL ovf: got err_ovf %b pending %b want 1 1", bus.err_ovf, bus.pending);
        else passes++;
        tick();
        bus.stall = 1'b0;
        tick();
        wait_commit("ovf_apply");
        bus.rs_addr = 3'd4;
        bus.rt_addr = 3'd5;
        #1;
        checks++;
        if (bus.rs_data !== 32'd9 || bus.rt_data !== 32'd0)
            $display("FAIL ovf_regs: got r4 %h r5 %h want 9 0", bus.rs_data, bus.rt_data);
        else passes++;
        tick();
        commit_one("r0_write", 3'd0, 1'b1, 32'd7, 1'b0, '0);
        bus.rs_addr = 3'd0;
        #1;
        checks++;
        if (bus.rs_data !== 32'h0) $display("FAIL r0: got %h want 0", bus.rs_data);
        else passes++;
    endtask

    task automatic test_wrap();
        commit_one("to_top", 3'd0, 1'b0, '0, 1'b1, 32'hFFFFFFFC);
        commit_one("pc_wrap", 3'd0, 1'b0, '0, 1'b0, '0);
        checks++;
        if (bus.pc !== 32'h0) $display("FAIL pc_wrap_zero: got %h want 0", bus.pc);
        else passes++;
        while (m_cnt != 8'hFF) commit_one("cnt_run", 3'd1, 1'b1, 32'(m_cnt), 1'b0, '0);
        checks++;
        if (bus.commit_cnt !== 8'hFF) $display("FAIL cnt_top: got %h want ff", bus.commit_cnt);
        else passes++;
        commit_one("cnt_wrap", 3'd0, 1'b0, '0, 1'b0, '0);
        checks++;
        if (bus.commit_cnt !== 8'h00) $display("FAIL cnt_wrap_zero: got %h want 0", bus.commit_cnt);
        else passes++;
    endtask

    task automatic test_reset_mid_stall();
        bus.stall = 1'b1;
        drive_ev(3'd1, 1'b1, 32'h11, 1'b0, '0);
        tick();
        bus.start = '0;
        checks++;
        if (bus.pending !== 1'b1) $display("FAIL pre_rst_pending: got %b want 1", bus.pending);
        else passes++;
        rst_n = 1'b0;
        #1;
        exp_pc_q.delete();
        exp_cnt_q.delete();
        m_pc = '0;
        m_cnt = '0;
        test_reset();
        bus.stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.pending !== 1'b0 || bus.pc !== 32'h0 || bus.commit_cnt !== '0)
            $display("FAIL post_rst: got pending %b pc %h cnt %h want 0 0 0",
                     bus.pending, bus.pc, bus.commit_cnt);
        else passes++;
    endtask

    initial begin
        idle();
        m_pc = '0;
        m_cnt = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        test_alu_write();
        test_branch();
        test_stall();
        test_back_to_back();
        test_overflow_r0();
        test_wrap();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
